maxpool_2x2_stream: RTL and testbench

//  2x2 stride-2 max-pooling stage directly downstream of the 3x3 convolution filter.

---
 rtl/maxpool_2x2_stream.sv | 113 +++++++++++
 tb/tb_maxpool_2x2_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_2x2_stream.sv
// 2x2 stride-2 max-pooling stage for the raster-order conv output stream.
// Even rows park horizontal pair maxima in a half-width line buffer; odd rows emit pooled pixels.
module maxpool_2x2_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IN_DIM = 26
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic [DATA_W-1:0] pixel_i,
    input  logic              pixel_valid_i,
    input  logic              image_done_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid_o,
    output logic              frame_done_o,
    output logic              frame_err_o
);

    localparam int unsigned OUT_DIM = IN_DIM / 2;
    localparam int unsigned CW      = $clog2(IN_DIM);
    localparam logic [CW-1:0] LAST     = CW'(IN_DIM - 1);
    localparam logic [CW-1:0] LAST_OUT = CW'(2 * OUT_DIM - 1);

    typedef enum logic {
        RowEven,
        RowOdd
    } state_e;

    state_e            state;
    logic [CW-1:0]     col_cnt;
    logic [CW-1:0]     row_cnt;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] linebuf [OUT_DIM];

    logic [CW-2:0]     lb_idx;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] lb_rd;
    logic [DATA_W-1:0] vmax;
    logic              col_last;
    logic              row_last;
    logic [CW-1:0]     col_app;
    logic [CW-1:0]     row_app;
    logic              abort;

    always_comb begin
        lb_idx   = col_cnt[CW-1:1];
        hmax     = (pixel_i > hold_q) ? pixel_i : hold_q;
        lb_rd    = linebuf[lb_idx];
        vmax     = (lb_rd > hmax) ? lb_rd : hmax;
        col_last = (col_cnt == LAST);
        row_last = (row_cnt == LAST);
        col_app  = col_cnt;
        row_app  = row_cnt;
        if (pixel_valid_i) begin
            if (col_last) begin
                col_app = '0;
                row_app = row_last ? '0 : row_cnt + 1'b1;
            end else begin
                col_app = col_cnt + 1'b1;
            end
        end
        // End-of-image only counts as an error if it lands inside a frame.
        abort = image_done_i && ((col_app != '0) || (row_app != '0));
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state         <= RowEven;
            col_cnt       <= '0;
            row_cnt       <= '0;
            hold_q        <= '0;
            pixel_o       <= '0;
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            pixel_valid_o <= 1'b0;
            frame_done_o  <= 1'b0;
            frame_err_o   <= abort;
            if (pixel_valid_i) begin
                if (!col_cnt[0]) begin
                    hold_q <= pixel_i;
                end else if (state == RowOdd) begin
                    pixel_o       <= vmax;
                    pixel_valid_o <= 1'b1;
                    frame_done_o  <= (row_cnt == LAST_OUT) && (col_cnt == LAST_OUT);
                end
                if (col_last) begin
                    case (state)
                        RowEven: state <= row_last ? RowEven : RowOdd;
                        RowOdd:  state <= RowEven;
                        default: state <= RowEven;
                    endcase
                end
            end
            if (abort) begin
                col_cnt <= '0;
                row_cnt <= '0;
                state   <= RowEven;
            end else begin
                col_cnt <= col_app;
                row_cnt <= row_app;
            end
        end
    end

    // Contents are don't-care after reset: every entry is rewritten on row 0 before it is read.
    always_ff @(posedge clk_i) begin
        if (pixel_valid_i && col_cnt[0] && (state == RowEven)) begin
            linebuf[lb_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream: ramp frames, bubbles, single peak, abort, reset.
module tb_maxpool_2x2_stream;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pixel_i = '0;
    logic       pixel_valid_i = 1'b0;
    logic       image_done_i = 1'b0;
    logic [7:0] pixel_o;
    logic       pixel_valid_o;
    logic       frame_done_o;
    logic       frame_err_o;

    int total = 0;
    int bad   = 0;

    maxpool_2x2_stream #(
        .DATA_W(8),
        .IN_DIM(26)
    ) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .pixel_i      (pixel_i),
        .pixel_valid_i(pixel_valid_i),
        .image_done_i (image_done_i),
        .pixel_o      (pixel_o),
        .pixel_valid_o(pixel_valid_o),
        .frame_done_o (frame_done_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] p, input logic v, input logic d);
        pixel_i       = p;
        pixel_valid_i = v;
        image_done_i  = d;
        @(posedge clk_i);
        #1;
        pixel_valid_i = 1'b0;
        image_done_i  = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk_i);
        #1;
        reset = 1'b1;
        #2;
        total++; if (pixel_o !== 8'd0) begin bad++; $display("FAIL reset_pixel: got %0d expected 0", pixel_o); end
        total++; if (pixel_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", pixel_valid_o); end
        total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", frame_done_o); end
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", frame_err_o); end
        @(posedge clk_i);
        #1;
        reset = 1'b0;
    endtask

    // Full 26x26 ramp frame pixel(r,c)=r*9+c; the 2x2 max is the bottom-right pixel of each block.
    task automatic test_ramp_frame(input string name, input int pct, input bit done_last,
                                   output int n_done);
        int  obs;
        bit  exp_v;
        bit  last;
        obs    = 0;
        n_done = 0;
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                for (int k = 0; k < 3 && $urandom_range(99) < pct; k++) begin
                    send(8'($urandom_range(255)), 1'b0, 1'b0);
                    total++;
                    if (pixel_valid_o !== 1'b0 || frame_done_o !== 1'b0) begin
                        bad++;
                        $display("FAIL %s_bubble: got valid=%b done=%b expected 0 0",
                                 name, pixel_valid_o, frame_done_o);
                    end
                end
                last  = (r == 25) && (c == 25);
                exp_v = (r % 2 == 1) && (c % 2 == 1);
                send(8'(r * 9 + c), 1'b1, done_last && last);
                obs += int'(pixel_valid_o);
                n_done += int'(frame_done_o);
                total++;
                if (pixel_valid_o !== exp_v) begin
                    bad++;
                    $display("FAIL %s_valid r=%0d c=%0d: got %b expected %b",
                             name, r, c, pixel_valid_o, exp_v);
                end
                if (exp_v) begin
                    total++;
                    if (pixel_o !== 8'(r * 9 + c)) begin
                        bad++;
                        $display("FAIL %s_pixel r=%0d c=%0d: got %0d expected %0d",
                                 name, r, c, pixel_o, r * 9 + c);
                    end
                end
                total++;
                if (frame_done_o !== last) begin
                    bad++;
                    $display("FAIL %s_done r=%0d c=%0d: got %b expected %b",
                             name, r, c, frame_done_o, last);
                end
                total++;
                if (frame_err_o !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_err r=%0d c=%0d: got %b expected 0", name, r, c, frame_err_o);
                end
            end
        end
        total++;
        if (obs != 169) begin bad++; $display("FAIL %s_count: got %0d expected 169", name, obs); end
    endtask

    task automatic test_continuous();
        int nd;
        test_ramp_frame("cont", 0, 1'b0, nd);
        total++; if (nd != 1) begin bad++; $display("FAIL cont_done_count: got %0d expected 1", nd); end
    endtask

    task automatic test_bubbles();
        int nd;
        test_ramp_frame("bubble", 30, 1'b0, nd);
        total++; if (nd != 1) begin bad++; $display("FAIL bubble_done_count: got %0d expected 1", nd); end
    endtask

    // Single 255 at (5,8) lands in block (2,4), emitted while accepting (5,9).
    task automatic test_single_peak();
        int  n255;
        bit  exp_v;
        n255 = 0;
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                send((r == 5 && c == 8) ? 8'd255 : 8'd0, 1'b1, 1'b0);
                exp_v = (r % 2 == 1) && (c % 2 == 1);
                if (exp_v) begin
                    total++;
                    if (pixel_valid_o !== 1'b1 ||
                        pixel_o !== ((r == 5 && c == 9) ? 8'd255 : 8'd0)) begin
                        bad++;
                        $display("FAIL peak_pixel r=%0d c=%0d: got valid=%b %0d expected 1 %0d", r, c,
                                 pixel_valid_o, pixel_o, (r == 5 && c == 9) ? 255 : 0);
                    end
                    if (pixel_o == 8'd255) n255++;
                end
            end
        end
        total++; if (n255 != 1) begin bad++; $display("FAIL peak_count: got %0d expected 1", n255); end
    endtask

    task automatic test_abort();
        int nd;
        for (int i = 0; i < 100; i++) begin
            send(8'((i / 26) * 9 + (i % 26)), 1'b1, i == 99);
            if (i < 99) begin
                total++;
                if (frame_err_o !== 1'b0) begin bad++; $display("FAIL abort_early_err i=%0d: got 1 expected 0", i); end
            end
        end
        total++; if (frame_err_o !== 1'b1) begin bad++; $display("FAIL abort_err: got %b expected 1", frame_err_o); end
        total++; if (frame_done_o !== 1'b0) begin bad++; $display("FAIL abort_done: got %b expected 0", frame_done_o); end
        send(8'd0, 1'b0, 1'b0);
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL abort_err_pulse: got %b expected 0", frame_err_o); end
        send(8'd0, 1'b0, 1'b1);
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL idle_done_err: got %b expected 0", frame_err_o); end
        test_ramp_frame("after_abort", 0, 1'b0, nd);
        total++; if (nd != 1) begin bad++; $display("FAIL after_abort_done_count: got %0d expected 1", nd); end
    endtask

    task automatic test_reset_mid();
        int nd;
        for (int i = 0; i < 33; i++) send(8'd255, 1'b1, 1'b0);
        reset = 1'b1;
        #2;
        total++; if (pixel_valid_o !== 1'b0 || pixel_o !== 8'd0) begin
            bad++; $display("FAIL midreset_out: got valid=%b %0d expected 0 0", pixel_valid_o, pixel_o);
        end
        @(posedge clk_i);
        #1;
        reset = 1'b0;
        test_ramp_frame("after_reset", 0, 1'b0, nd);
        total++; if (nd != 1) begin bad++; $display("FAIL after_reset_done_count: got %0d expected 1", nd); end
    endtask

    task automatic test_back_to_back();
        int nd0;
        int nd1;
        test_ramp_frame("b2b0", 0, 1'b1, nd0);
        test_ramp_frame("b2b1", 0, 1'b1, nd1);
        total++; if (nd0 + nd1 != 2) begin bad++; $display("FAIL b2b_done_count: got %0d expected 2", nd0 + nd1); end
        send(8'd0, 1'b0, 1'b0);
        total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b expected 0", frame_err_o); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_bubbles();
        test_single_peak();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
